// File: rtl/if_prefetch_unit_if.sv
// Instruction memory bus between the prefetch unit (master) and the
// instruction memory (slave): valid/ready request channel plus an
// in-order, never back-pressured response channel.
interface if_prefetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/if_prefetch_unit.sv
// Instruction fetch front end. Owns the fetch PC, issues word requests to a
// variable-latency instruction memory, buffers returned words with their PCs
// in a DEPTH-entry FIFO and hands them to ID under valid/ready. A redirect
// from EX clears the FIFO and turns every in-flight fetch into a discard.
// Optional feature: define IF_PERF_CNT_EN to build the fetched/flushed
// performance counters; otherwise both counters read as zero.
module if_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic               clk,
  input  logic               rst,
  if_prefetch_unit_if.master imem,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               instr_valid,
  input  logic               id_ready,
  output logic [31:0]        instr,
  output logic [31:0]        instr_pc,
  output logic [31:0]        pc_plus4,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_flushed
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  // Wide enough that the credit sum can never wrap.
  localparam int unsigned SUM_W = CNT_W + 2;
  localparam logic [SUM_W-1:0] DEPTH_C = SUM_W'(DEPTH);

  logic [31:0]      fetch_pc_reg, fetch_pc_next;
  logic [31:0]      rsp_pc_reg, rsp_pc_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] fifo_cnt_reg, fifo_cnt_next;
  logic [CNT_W-1:0] outstanding_reg, outstanding_next;
  logic [CNT_W-1:0] discard_reg, discard_next;

  logic [31:0] fifo_data [DEPTH];
  logic [31:0] fifo_pc   [DEPTH];

  logic [SUM_W-1:0] credit_used;
  logic             req_fire;
  logic             rsp_drop;
  logic             rsp_take;
  logic             push;
  logic             pop;

  // Handshake decode. A response is charged to the discard count first; one
  // arriving with nothing outstanding or discarded is ignored.
  always_comb begin
    credit_used = SUM_W'(fifo_cnt_reg) + SUM_W'(outstanding_reg) + SUM_W'(discard_reg);
    imem.imem_req_valid = !rst && !redirect_valid && (credit_used < DEPTH_C);
    imem.imem_req_addr  = fetch_pc_reg;
    req_fire    = imem.imem_req_valid && imem.imem_req_ready;
    rsp_drop    = imem.imem_rsp_valid && (discard_reg != '0);
    rsp_take    = imem.imem_rsp_valid && (discard_reg == '0) && (outstanding_reg != '0);
    push        = rsp_take && !redirect_valid;
    instr_valid = !rst && (fifo_cnt_reg != '0) && !redirect_valid;
    pop         = instr_valid && id_ready;
    instr       = fifo_data[rd_ptr_reg];
    instr_pc    = fifo_pc[rd_ptr_reg];
    pc_plus4    = fifo_pc[rd_ptr_reg] + 32'd4;
  end

  // Next-state: a redirect overrides any same-cycle push, pop or accept.
  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    rsp_pc_next      = rsp_pc_reg;
    wr_ptr_next      = wr_ptr_reg;
    rd_ptr_next      = rd_ptr_reg;
    fifo_cnt_next    = fifo_cnt_reg;
    outstanding_next = outstanding_reg;
    discard_next     = discard_reg;
    if (redirect_valid) begin
      fetch_pc_next    = redirect_pc;
      rsp_pc_next      = redirect_pc;
      wr_ptr_next      = '0;
      rd_ptr_next      = '0;
      fifo_cnt_next    = '0;
      outstanding_next = '0;
      discard_next     = discard_reg + outstanding_reg - CNT_W'(rsp_drop || rsp_take);
    end else begin
      if (req_fire) begin
        fetch_pc_next = fetch_pc_reg + 32'd4;
      end
      outstanding_next = outstanding_reg + CNT_W'(req_fire) - CNT_W'(rsp_take);
      discard_next     = discard_reg - CNT_W'(rsp_drop);
      if (push) begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        rsp_pc_next = rsp_pc_reg + 32'd4;
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      fifo_cnt_next = fifo_cnt_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control state; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_reg    <= RESET_PC;
      rsp_pc_reg      <= RESET_PC;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      fifo_cnt_reg    <= '0;
      outstanding_reg <= '0;
      discard_reg     <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      rsp_pc_reg      <= rsp_pc_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      fifo_cnt_reg    <= fifo_cnt_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
    end
  end

  // FIFO storage write; contents need no reset since fifo_cnt gates them.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr_reg] <= imem.imem_rsp_data;
      fifo_pc[wr_ptr_reg]   <= rsp_pc_reg;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched_reg;
  logic [31:0] perf_flushed_reg;
  logic [31:0] flush_inc;

  // Words lost this cycle: cleared entries plus a killed/dropped response.
  always_comb begin
    if (redirect_valid) begin
      flush_inc = 32'(fifo_cnt_reg) +
                  32'(imem.imem_rsp_valid && ((discard_reg != '0) || (outstanding_reg != '0)));
    end else begin
      flush_inc = 32'(rsp_drop);
    end
  end

  // Free-running performance counters, wrapping at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_reg <= '0;
      perf_flushed_reg <= '0;
    end else begin
      perf_fetched_reg <= perf_fetched_reg + 32'(push);
      perf_flushed_reg <= perf_flushed_reg + flush_inc;
    end
  end

  assign perf_fetched = perf_fetched_reg;
  assign perf_flushed = perf_flushed_reg;
`else
  assign perf_fetched = 32'h0;
  assign perf_flushed = 32'h0;
`endif

  // A response must always belong to an outstanding or discarded fetch.
  assert property (@(posedge clk) disable iff (rst)
                   imem.imem_rsp_valid |-> ((outstanding_reg != '0) || (discard_reg != '0)))
    else $error("imem response with nothing outstanding or discarded");

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Randomized scoreboard bench for if_prefetch_unit. A memory model answers
// accepted requests in order after a random latency; every response that
// belongs to the current fetch path is pushed as an expected {pc, word} pair,
// and a separate monitor pops and compares whenever ID consumes an entry.
`timescale 1ns/1ps
module tb_if_prefetch_unit;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        id_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;

  if_prefetch_unit_if imem ();

  if_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (imem),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .id_ready       (id_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .pc_plus4       (pc_plus4),
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int epoch; int rdy; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

  mreq_t mem_q[$];   // requests accepted by the memory, not yet answered
  exp_t  sb_q[$];    // words ID must still receive, in order

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int epoch = 0;
  int n_rsp = 0, n_push = 0, n_pop = 0, n_acc = 0;
  int p_ready = 100, p_idr = 100, p_redir = 0, p_rsp = 100, lat_x = 0;
  int fresh = 0;
  bit in_rst = 1'b1;
  bit rel_pending = 1'b0;
  bit redir_now = 1'b0;
  bit force_redir = 1'b0;
  logic [31:0] force_pc = 32'h0;
  logic [31:0] exp_fetch = RESET_PC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic bit chance(input int p);
    return int'($urandom_range(99, 0)) < p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus: drive at negedge, evaluate handshakes 1ns later.
  task automatic one_cycle();
    bit          rsp;
    bit          exp_req;
    int          used;
    mreq_t       h;
    logic [31:0] rpc;
    @(negedge clk);
    cyc++;
    if (rel_pending) begin
      rst = 1'b0;
      in_rst = 1'b0;
      rel_pending = 1'b0;
    end
    redir_now = force_redir || chance(p_redir);
    rpc = $urandom();
    rpc[1:0] = 2'b00;
    if (chance(25)) rpc = 32'hFFFF_FFFC;
    redirect_valid = redir_now;
    redirect_pc = force_redir ? force_pc : rpc;
    force_redir = 1'b0;
    rsp = (mem_q.size() > 0) && (mem_q[0].rdy <= cyc) && chance(p_rsp);
    imem.imem_rsp_valid = rsp;
    imem.imem_rsp_data  = rsp ? mem_word(mem_q[0].addr) : $urandom();
    imem.imem_req_ready = chance(p_ready);
    id_ready = chance(p_idr);
    #1;
    // Buffered words plus everything the memory still owes must stay under DEPTH.
    used = mem_q.size() + sb_q.size();
    exp_req = !redir_now && (used < DEPTH);
    check("req_valid", 32'(imem.imem_req_valid), 32'(exp_req));
    fresh = 0;
    if (rsp) begin
      h = mem_q.pop_front();
      n_rsp++;
      if (!redir_now && h.epoch == epoch) begin
        sb_q.push_back('{pc: h.addr, data: mem_word(h.addr)});
        n_push++;
        fresh = 1;
      end
    end
    if (redir_now) begin
      sb_q.delete();
      epoch++;
      exp_fetch = redirect_pc;
    end
    if (imem.imem_req_valid && imem.imem_req_ready) begin
      n_acc++;
      check("req_addr", imem.imem_req_addr, exp_fetch);
      mem_q.push_back('{addr: imem.imem_req_addr, epoch: epoch,
                        rdy: cyc + 1 + int'($urandom_range(lat_x, 0))});
      exp_fetch = exp_fetch + 32'd4;
    end
  endtask

  // Assert reset mid-cycle; release happens at the start of the next one_cycle.
  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    in_rst = 1'b1;
    redirect_valid = 1'b0;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_req_ready = 1'b1;
    id_ready = 1'b1;
    #1;
    check("rst_req_valid", 32'(imem.imem_req_valid), 32'h0);
    check("rst_instr_valid", 32'(instr_valid), 32'h0);
    check("rst_perf_fetched", perf_fetched, 32'h0);
    check("rst_perf_flushed", perf_flushed, 32'h0);
    repeat (cycles) @(negedge clk);
    mem_q.delete();
    sb_q.delete();
    epoch++;
    exp_fetch = RESET_PC;
    n_rsp = 0;
    n_push = 0;
    n_pop = 0;
    redir_now = 1'b0;
    fresh = 0;
    rel_pending = 1'b1;
  endtask

  // Monitor: whenever ID takes a word, it must be the oldest expected one.
  initial begin : monitor
    bit   exp_v;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!in_rst) begin
        exp_v = !redir_now && (sb_q.size() > fresh);
        check("instr_valid", 32'(instr_valid), 32'(exp_v));
        if (instr_valid && id_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pop: got pc %h with nothing expected (cycle %0d)", instr_pc, cyc);
          end else begin
            e = sb_q.pop_front();
            n_pop++;
            check("instr_pc", instr_pc, e.pc);
            check("instr", instr, e.data);
            check("pc_plus4", pc_plus4, e.pc + 32'd4);
            $display("pop cycle=%0d pc=%h instr=%h", cyc, instr_pc, instr);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    id_ready = 1'b0;
    imem.imem_req_ready = 1'b0;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data = 32'h0;
    do_reset(3);

    // ID stalled, memory always ready: exactly DEPTH requests go out.
    p_ready = 100; p_idr = 0; p_redir = 0; p_rsp = 100; lat_x = 0;
    n_acc = 0;
    repeat (12) one_cycle();
    check("stall_req_count", 32'(n_acc), 32'(DEPTH));

    // Streaming: one-cycle memory, ID always ready.
    p_idr = 100;
    repeat (20) one_cycle();

    // Random traffic with redirects.
    p_ready = 70; p_idr = 60; p_redir = 4; p_rsp = 70; lat_x = 3;
    repeat (3000) one_cycle();

    // Redirect to the top of the address space, then drain everything.
    p_ready = 100; p_idr = 100; p_redir = 0; p_rsp = 100; lat_x = 0;
    force_redir = 1'b1;
    force_pc = 32'hFFFF_FFFC;
    repeat (40) one_cycle();

`ifdef IF_PERF_CNT_EN
    check("perf_fetched", perf_fetched, 32'(n_push));
    check("perf_flushed", perf_flushed, 32'(n_rsp - n_pop));
`else
    check("perf_fetched", perf_fetched, 32'h0);
    check("perf_flushed", perf_flushed, 32'h0);
`endif

    // Build up outstanding fetches, then reset in the middle of them.
    p_rsp = 0; p_idr = 0;
    repeat (6) one_cycle();
    do_reset(2);
    p_rsp = 100; p_idr = 100;
    repeat (20) one_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
